// File: rtl/jtframe_z80_multiwait_pkg.sv
// Shared definitions for the Z80 multi-channel wait / cen recovery logic.
// Also used by the jtframe CPU wrappers, so keep the encodings stable.
package jtframe_z80_multiwait_pkg;

    // Gating FSM states
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RECOVER = 2'd2
    } mw_state_t;

    // Clock cycles between a cen_in pulse and the repaid pulse that follows it
    localparam logic [1:0] INS_OFFSET = 2'd2;

endpackage

// File: rtl/jtframe_z80_cenrec.sv
// Missed-pulse bookkeeping: saturating miss counter, phase since the last
// cen_in and the insertion of repaid pulses at cen_in + INS_OFFSET.
module jtframe_z80_cenrec
    import jtframe_z80_multiwait_pkg::*;
#(
    parameter int CNTW = 4
)(
    input  logic            rst_n,
    input  logic            clk,
    input  logic            cen_in,
    input  logic            miss_inc,   // a cen_in pulse was withheld
    input  logic            miss_clr,   // drop the whole balance
    input  logic            ins_en,     // insertion allowed this cycle
    output logic            ins_pulse,  // repaid pulse this cycle
    output logic [CNTW-1:0] miss
);

    localparam logic [CNTW-1:0] MISS_MAX = '1;

    logic [1:0]      phase_q, phase_d;
    logic [CNTW-1:0] miss_q,  miss_d;

    // Phase tracking, insertion decision and miss counter update
    always_comb begin
        ins_pulse = ins_en & (phase_q == INS_OFFSET) & (miss_q != '0);

        // phase 0 means no cen_in seen yet; it stops at 3 until the next cen_in
        phase_d = phase_q;
        if (cen_in) begin
            phase_d = 2'd1;
        end else if (phase_q != 2'd0 && phase_q != 2'd3) begin
            phase_d = phase_q + 2'd1;
        end

        miss_d = miss_q;
        if (miss_clr) begin
            miss_d = '0;
        end else if (miss_inc) begin
            if (miss_q != MISS_MAX) begin
                miss_d = miss_q + CNTW'(1);
            end
        end else if (ins_pulse) begin
            miss_d = miss_q - CNTW'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 2'd0;
            miss_q  <= '0;
        end else begin
            phase_q <= phase_d;
            miss_q  <= miss_d;
        end
    end

    assign miss = miss_q;

endmodule

// File: rtl/jtframe_z80_multiwait.sv
// Z80 clock-enable gating: stalls the CPU while a ROM channel or a shared
// device is not ready, repays withheld cen pulses afterwards and breaks
// stalls that never end with a sticky watchdog.
module jtframe_z80_multiwait
    import jtframe_z80_multiwait_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int RECOVERY = 1,
    parameter int CNTW     = 4,
    parameter int TOW      = 10
)(
    input  logic           rst_n,
    input  logic           clk,
    input  logic           cen_in,
    output logic           cen_out,
    output logic           gate,
    input  logic           mreq_n,
    input  logic           iorq_n,
    input  logic           busak_n,
    input  logic [NCH-1:0] rom_cs,
    input  logic [NCH-1:0] rom_ok,
    input  logic           dev_busy,
    output logic           timeout
);

    localparam logic [TOW-1:0] WD_MAX = '1;

    mw_state_t       state_q, state_d;
    logic [NCH-1:0]  cs_l_q, cs_l_d;
    logic [TOW-1:0]  wd_q, wd_d;
    logic            timeout_q, timeout_d;
    logic            cut_q, cut_d;

    logic [NCH-1:0]  pend;
    logic            req;
    logic            wd_hit;
    logic            miss_inc, miss_clr, ins_en, ins_pulse;
    logic [CNTW-1:0] miss;

    // Wait request; a channel is not trusted in the first cycle of its select
    always_comb begin
        cs_l_d = rom_cs;
        pend   = rom_cs & (~rom_ok | ~cs_l_q);
        req    = busak_n & ~cut_q &
                 ((~mreq_n & (|pend)) | (dev_busy & (~mreq_n | ~iorq_n)));
        // a cen_in colliding with req sends RECOVER back to WAIT: no insertion then
        ins_en = (state_q == ST_RECOVER) & ~(cen_in & req);
    end

    jtframe_z80_cenrec #(
        .CNTW      (CNTW)
    ) u_cenrec (
        .rst_n     (rst_n),
        .clk       (clk),
        .cen_in    (cen_in),
        .miss_inc  (miss_inc),
        .miss_clr  (miss_clr),
        .ins_en    (ins_en),
        .ins_pulse (ins_pulse),
        .miss      (miss)
    );

    // Gating FSM: next state, gated cen and miss counter controls
    always_comb begin
        state_d  = state_q;
        cen_out  = 1'b0;
        gate     = 1'b1;
        miss_inc = 1'b0;
        miss_clr = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_RUN: begin
                    cen_out = cen_in & ~req;
                    if (cen_in && req) begin
                        gate     = 1'b0;
                        miss_inc = 1'b1;
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    gate     = 1'b0;
                    miss_inc = cen_in;
                    if (!req) begin
                        if (RECOVERY != 0 && miss != '0) begin
                            state_d = ST_RECOVER;
                        end else begin
                            miss_clr = 1'b1;
                            state_d  = ST_RUN;
                        end
                    end
                end
                ST_RECOVER: begin
                    if (cen_in && req) begin
                        gate     = 1'b0;
                        miss_inc = 1'b1;
                        state_d  = ST_WAIT;
                    end else begin
                        cen_out = cen_in | ins_pulse;
                        if ((ins_pulse && miss == CNTW'(1)) || miss == '0) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: begin
                    miss_clr = 1'b1;
                    state_d  = ST_RUN;
                end
            endcase
        end
    end

    // Watchdog: counts clk cycles spent in WAIT and cuts the request at the limit
    always_comb begin
        wd_hit    = (state_q == ST_WAIT) && (wd_q == WD_MAX - TOW'(1));
        if (state_q == ST_WAIT) begin
            wd_d  = (wd_q == WD_MAX) ? wd_q : wd_q + TOW'(1);
            cut_d = cut_q | wd_hit;
        end else begin
            wd_d  = '0;
            cut_d = 1'b0;
        end
        timeout_d = timeout_q | wd_hit;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            cs_l_q    <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            cut_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cs_l_q    <= cs_l_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            cut_q     <= cut_d;
        end
    end

    assign timeout = timeout_q;

endmodule

// File: tb/tb_jtframe_z80_multiwait.sv
// Bench for jtframe_z80_multiwait: four instances with different parameters
// share the stimulus; a per-cycle scoreboard checks the selected instance.
module tb_jtframe_z80_multiwait;

    logic       clk;
    logic       rst_n;
    logic       cen_in;
    logic       mreq_n, iorq_n, busak_n, dev_busy;
    logic [1:0] rom_cs, rom_ok;

    logic cen_a, gate_a, tmo_a;   // defaults
    logic cen_w, gate_w, tmo_w;   // TOW = 4
    logic cen_s, gate_s, tmo_s;   // CNTW = 2, recovery
    logic cen_n, gate_n, tmo_n;   // CNTW = 2, no recovery

    typedef struct {
        int   ph;
        int   t;
        logic ec;
        logic eg;
        logic et;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic oc, og, ot;
    int   sel;
    int   n_checks;
    int   n_errors;

    jtframe_z80_multiwait u_a (
        .rst_n(rst_n), .clk(clk), .cen_in(cen_in), .cen_out(cen_a), .gate(gate_a),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .busak_n(busak_n), .rom_cs(rom_cs),
        .rom_ok(rom_ok), .dev_busy(dev_busy), .timeout(tmo_a)
    );

    jtframe_z80_multiwait #(.TOW(4)) u_w (
        .rst_n(rst_n), .clk(clk), .cen_in(cen_in), .cen_out(cen_w), .gate(gate_w),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .busak_n(busak_n), .rom_cs(rom_cs),
        .rom_ok(rom_ok), .dev_busy(dev_busy), .timeout(tmo_w)
    );

    jtframe_z80_multiwait #(.CNTW(2)) u_s (
        .rst_n(rst_n), .clk(clk), .cen_in(cen_in), .cen_out(cen_s), .gate(gate_s),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .busak_n(busak_n), .rom_cs(rom_cs),
        .rom_ok(rom_ok), .dev_busy(dev_busy), .timeout(tmo_s)
    );

    jtframe_z80_multiwait #(.CNTW(2), .RECOVERY(0)) u_n (
        .rst_n(rst_n), .clk(clk), .cen_in(cen_in), .cen_out(cen_n), .gate(gate_n),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .busak_n(busak_n), .rom_cs(rom_cs),
        .rom_ok(rom_ok), .dev_busy(dev_busy), .timeout(tmo_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int ph, input int t, input logic ec, input logic eg,
                            input logic et);
        exp_t e;
        e.ph = ph;
        e.t  = t;
        e.ec = ec;
        e.eg = eg;
        e.et = et;
        sb_q.push_back(e);
    endtask

    task automatic idle_inputs();
        cen_in   = 1'b0;
        mreq_n   = 1'b1;
        iorq_n   = 1'b1;
        busak_n  = 1'b1;
        dev_busy = 1'b0;
        rom_cs   = 2'b00;
        rom_ok   = 2'b11;
    endtask

    task automatic do_reset();
        tick();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // Scoreboard consumer: one expected entry per driven cycle
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            case (sel)
                0:       begin oc = cen_a; og = gate_a; ot = tmo_a; end
                1:       begin oc = cen_w; og = gate_w; ot = tmo_w; end
                2:       begin oc = cen_s; og = gate_s; ot = tmo_s; end
                default: begin oc = cen_n; og = gate_n; ot = tmo_n; end
            endcase
            check_eq($sformatf("p%0d_t%0d_cen_out", mon_e.ph, mon_e.t), int'(oc), int'(mon_e.ec));
            check_eq($sformatf("p%0d_t%0d_gate", mon_e.ph, mon_e.t), int'(og), int'(mon_e.eg));
            check_eq($sformatf("p%0d_t%0d_timeout", mon_e.ph, mon_e.t), int'(ot), int'(mon_e.et));
        end
    end

    // Saturating stall of 6 cen_in pulses on a CNTW = 2 instance
    task automatic run_sat(input int ph, input bit rec);
        logic c, ec, eg;
        do_reset();
        for (int t = 0; t < 48; t++) begin
            tick();
            c      = (t % 4 == 0);
            cen_in = c;
            mreq_n = 1'b0;
            rom_cs = (t >= 1) ? 2'b10 : 2'b00;
            rom_ok = (t >= 3 && t <= 26) ? 2'b01 : 2'b11;
            eg = 1'b1;
            ec = c;
            if (t >= 4 && t <= 27) begin
                ec = 1'b0;
                eg = 1'b0;
            end else if (rec && t >= 28 && t <= 38) begin
                ec = (t % 2 == 0);
            end
            push_exp(ph, t, ec, eg, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic c, ec, eg, et;
        int   u;
        n_checks = 0;
        n_errors = 0;
        sel      = 0;
        idle_inputs();
        rst_n  = 1'b0;
        cen_in = 1'b1;   // an active cen_in must not leak through during reset
        repeat (2) @(negedge clk);
        check_eq("rst_cen_a", int'(cen_a), 0);
        check_eq("rst_gate_a", int'(gate_a), 1);
        check_eq("rst_tmo_a", int'(tmo_a), 0);
        check_eq("rst_cen_w", int'(cen_w), 0);
        check_eq("rst_gate_w", int'(gate_w), 1);
        check_eq("rst_tmo_w", int'(tmo_w), 0);
        check_eq("rst_cen_s", int'(cen_s), 0);
        check_eq("rst_gate_s", int'(gate_s), 1);
        check_eq("rst_tmo_s", int'(tmo_s), 0);
        check_eq("rst_cen_n", int'(cen_n), 0);
        check_eq("rst_gate_n", int'(gate_n), 1);
        check_eq("rst_tmo_n", int'(tmo_n), 0);
        tick();
        cen_in = 1'b0;
        rst_n  = 1'b1;

        // Phase 1: steady clocking, no selects
        for (int t = 0; t < 16; t++) begin
            tick();
            c      = (t % 4 == 0);
            cen_in = c;
            push_exp(1, t, c, 1'b1, 1'b0);
        end

        // Phase 2: channel 1 not ready for 20 clk, 5 pulses withheld and repaid
        do_reset();
        for (int t = 0; t < 60; t++) begin
            tick();
            c      = (t % 4 == 0);
            cen_in = c;
            mreq_n = 1'b0;
            rom_cs = (t >= 1) ? 2'b10 : 2'b00;
            rom_ok = (t >= 7 && t <= 26) ? 2'b01 : 2'b11;
            ec = c;
            eg = 1'b1;
            if (t >= 8 && t <= 27) begin
                ec = 1'b0;
                eg = 1'b0;
            end else if (t >= 28 && t <= 46) begin
                ec = (t % 2 == 0);
            end
            push_exp(2, t, ec, eg, 1'b0);
        end

        // Phase 3: fresh select on a cen_in cycle with data already valid
        do_reset();
        for (int t = 0; t < 20; t++) begin
            tick();
            c      = (t % 4 == 0);
            cen_in = c;
            mreq_n = 1'b0;
            rom_cs = (t >= 4) ? 2'b01 : 2'b00;
            ec = c;
            eg = 1'b1;
            if (t == 4 || t == 5) begin
                ec = 1'b0;
                eg = 1'b0;
            end else if (t == 6) begin
                ec = 1'b1;
            end
            push_exp(3, t, ec, eg, 1'b0);
        end

        // Phase 4: shared device busy on I/O, then bus handed over
        do_reset();
        for (int t = 0; t < 28; t++) begin
            tick();
            c        = (t % 4 == 0);
            cen_in   = c;
            dev_busy = (t >= 1);
            iorq_n   = !(t >= 1);
            busak_n  = !(t >= 10);
            ec = c;
            eg = 1'b1;
            if (t >= 4 && t <= 10) begin
                ec = 1'b0;
                eg = 1'b0;
            end else if (t == 14 || t == 18) begin
                ec = 1'b1;
            end
            push_exp(4, t, ec, eg, 1'b0);
        end

        // Phase 5: watchdog on the TOW = 4 instance, ROM never ready
        sel = 1;
        do_reset();
        for (int t = 0; t < 44; t++) begin
            tick();
            c      = (t % 4 == 0);
            cen_in = c;
            mreq_n = 1'b0;
            rom_cs = (t >= 1) ? 2'b01 : 2'b00;
            rom_ok = (t >= 1) ? 2'b10 : 2'b11;
            et = (t >= 20);
            ec = c;
            eg = 1'b1;
            if (t >= 4) begin
                u = (t - 4) % 20;
                if (u <= 16) begin
                    ec = 1'b0;
                    eg = 1'b0;
                end else begin
                    ec = (u == 18);
                end
            end
            push_exp(5, t, ec, eg, et);
        end
        tick();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("p5_tmo_cleared_by_reset", int'(tmo_w), 0);

        // Phase 6: saturation with and without recovery
        sel = 2;
        run_sat(6, 1'b1);
        tick();
        sel = 3;
        run_sat(7, 1'b0);
        tick();
        tick();
        check_eq("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
